// File: rtl/stepdown_pkg.sv
// Shared types and constants for the stepdown core-state sequencer.
package stepdown_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_WAIT_UV   = 3'd1,
    ST_SOFTSTART = 3'd2,
    ST_RUN       = 3'd3,
    ST_HICCUP    = 3'd4
  } state_t;

  localparam int SS_CODE_W = 8;
  localparam logic [SS_CODE_W-1:0] SS_CODE_RUN = 8'hFF;

endpackage

// File: rtl/stepdown_deglitch.sv
// Two-flop synchronizer followed by a stable-count filter: the output only
// follows the input after DGL_CYC consecutive synchronized samples disagree with it.
module stepdown_deglitch #(
  parameter int DGL_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam logic [3:0] DGL_LAST = 4'(DGL_CYC - 1);

  logic       sync1_r;
  logic       sync2_r;
  logic [3:0] cnt_r;
  logic       dout_r;

  // Metastability guard for the asynchronous input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
    end
  end

  // Run-length filter; any agreeing sample restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= 4'd0;
      dout_r <= 1'b0;
    end else if (sync2_r != dout_r) begin
      if (cnt_r == DGL_LAST) begin
        dout_r <= sync2_r;
        cnt_r  <= 4'd0;
      end else begin
        cnt_r <= cnt_r + 4'd1;
      end
    end else begin
      cnt_r <= 4'd0;
    end
  end

  assign dout = dout_r;

endmodule

// File: rtl/stepdown_corestate_seq.sv
// Core-state sequencer: OFF / WAIT_UV / SOFTSTART / RUN / HICCUP with a shared
// saturating counter, sticky fault flag and registered outputs.
module stepdown_corestate_seq
  import stepdown_pkg::*;
#(
  parameter int DGL_CYC   = 4,
  parameter int SS_CYC    = 256,
  parameter int RETRY_CYC = 1024,
  parameter int CNT_W     = 11
) (
  input  logic       CELCLK,
  input  logic       CELRST,
  input  logic       CELV,
  input  logic       CELG,
  input  logic       SUB,
  input  logic       en,
  input  logic       uvlo_ok,
  input  logic       ot,
  input  logic       ocp,
  output logic       core_on,
  output logic       ss_active,
  output logic [7:0] ss_code,
  output logic       fault,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   SS_LAST    = CNT_W'(SS_CYC - 1);
  localparam logic [CNT_W-1:0]   RETRY_LAST = CNT_W'(RETRY_CYC - 1);
  localparam logic [CNT_W+7:0]   SS_DIV     = (CNT_W + 8)'(SS_CYC);

  logic       pins_unused_s;
  logic       en_d_s, uv_d_s, ot_d_s;
  logic       ocp_s1_r, ocp_s2_r;
  state_t     state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
  logic       fault_r, fault_nxt_s;
  logic       core_on_r, ss_active_r;
  logic [SS_CODE_W-1:0] ss_code_r, ss_scaled_s;

  // Supply/substrate pins exist only for the brick netlist
  assign pins_unused_s = CELV ^ CELG ^ SUB;

  stepdown_deglitch #(.DGL_CYC(DGL_CYC)) u_dgl_en (.clk(CELCLK), .rst(CELRST), .din(en),      .dout(en_d_s));
  stepdown_deglitch #(.DGL_CYC(DGL_CYC)) u_dgl_uv (.clk(CELCLK), .rst(CELRST), .din(uvlo_ok), .dout(uv_d_s));
  stepdown_deglitch #(.DGL_CYC(DGL_CYC)) u_dgl_ot (.clk(CELCLK), .rst(CELRST), .din(ot),      .dout(ot_d_s));

  // Overcurrent is synchronized only, so it acts on its first synchronized cycle
  always_ff @(posedge CELCLK or posedge CELRST) begin
    if (CELRST) begin
      ocp_s1_r <= 1'b0;
      ocp_s2_r <= 1'b0;
    end else begin
      ocp_s1_r <= ocp;
      ocp_s2_r <= ocp_s1_r;
    end
  end

  assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);

  // Next-state and counter; disable beats faults, faults beat UVLO
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_OFF: begin
        cnt_nxt_s = CNT_ZERO;
        if (en_d_s) state_nxt_s = ST_WAIT_UV;
        else        state_nxt_s = ST_OFF;
      end
      ST_WAIT_UV: begin
        cnt_nxt_s = CNT_ZERO;
        if (!en_d_s)                 state_nxt_s = ST_OFF;
        else if (uv_d_s && !ot_d_s)  state_nxt_s = ST_SOFTSTART;
        else                         state_nxt_s = ST_WAIT_UV;
      end
      ST_SOFTSTART, ST_RUN: begin
        if (!en_d_s) begin
          state_nxt_s = ST_OFF;
          cnt_nxt_s   = CNT_ZERO;
        end else if (ocp_s2_r || ot_d_s) begin
          state_nxt_s = ST_HICCUP;
          cnt_nxt_s   = CNT_ZERO;
        end else if (!uv_d_s) begin
          state_nxt_s = ST_WAIT_UV;
          cnt_nxt_s   = CNT_ZERO;
        end else if (state_r == ST_SOFTSTART && cnt_r == SS_LAST) begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = CNT_ZERO;
        end else if (state_r == ST_SOFTSTART) begin
          cnt_nxt_s = cnt_inc_s;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HICCUP: begin
        if (!en_d_s) begin
          state_nxt_s = ST_OFF;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == RETRY_LAST) begin
          state_nxt_s = ST_WAIT_UV;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_inc_s;
        end
      end
      default: begin
        state_nxt_s = ST_OFF;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Fault is sticky across a restart and only dropped when the converter is turned off
  always_comb begin
    fault_nxt_s = fault_r;
    if (state_nxt_s == ST_OFF)                                fault_nxt_s = 1'b0;
    else if (state_nxt_s == ST_HICCUP && state_r != ST_HICCUP) fault_nxt_s = 1'b1;
    else                                                      fault_nxt_s = fault_r;
  end

  // Ramp code = counter * 256 / SS_CYC; a power-of-two SS_CYC reduces this to a slice
  assign ss_scaled_s = SS_CODE_W'({cnt_nxt_s, 8'h00} / SS_DIV);

  // State, counter and outputs, all decoded from the upcoming state
  always_ff @(posedge CELCLK or posedge CELRST) begin
    if (CELRST) begin
      state_r     <= ST_OFF;
      cnt_r       <= CNT_ZERO;
      fault_r     <= 1'b0;
      core_on_r   <= 1'b0;
      ss_active_r <= 1'b0;
      ss_code_r   <= 8'h00;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      fault_r     <= fault_nxt_s;
      core_on_r   <= (state_nxt_s == ST_SOFTSTART) || (state_nxt_s == ST_RUN);
      ss_active_r <= (state_nxt_s == ST_SOFTSTART);
      case (state_nxt_s)
        ST_SOFTSTART: ss_code_r <= ss_scaled_s;
        ST_RUN:       ss_code_r <= SS_CODE_RUN;
        default:      ss_code_r <= 8'h00;
      endcase
    end
  end

  assign core_on   = core_on_r;
  assign ss_active = ss_active_r;
  assign ss_code   = ss_code_r;
  assign fault     = fault_r;
  assign state     = state_r;

endmodule

// File: tb/tb_stepdown_corestate_seq.sv
// Directed bench for stepdown_corestate_seq with a cycle-level reference model
// built from input sample history, plus literal checkpoints.
module tb_stepdown_corestate_seq;

  localparam int DGL   = 4;
  localparam int SS    = 256;
  localparam int RETRY = 1024;

  logic CELCLK = 1'b0;
  logic CELRST = 1'b1;
  logic CELV = 1'b1, CELG = 1'b0, SUB = 1'b0;
  logic en = 1'b0, uvlo_ok = 1'b1, ot = 1'b0, ocp = 1'b0;
  logic       core_on, ss_active, fault;
  logic [7:0] ss_code;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // reference model: raw input sample histories (bit 0 = newest edge)
  logic [15:0] h_en, h_uv, h_ot, h_ocp;
  bit m_en_d, m_uv_d, m_ot_d, m_fault;
  int m_st, m_cnt;

  stepdown_corestate_seq dut (
    .CELCLK(CELCLK), .CELRST(CELRST), .CELV(CELV), .CELG(CELG), .SUB(SUB),
    .en(en), .uvlo_ok(uvlo_ok), .ot(ot), .ocp(ocp),
    .core_on(core_on), .ss_active(ss_active), .ss_code(ss_code),
    .fault(fault), .state(state)
  );

  always #5 CELCLK = ~CELCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CELCLK);
    #2;
  endtask

  // a filtered level flips once the samples two to DGL+1 edges old all disagree with it
  function automatic bit run_differs(input logic [15:0] h, input bit d);
    for (int i = 2; i <= DGL + 1; i++)
      if (h[i] == d) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    h_en = '0; h_uv = '0; h_ot = '0; h_ocp = '0;
    m_en_d = 0; m_uv_d = 0; m_ot_d = 0; m_fault = 0;
    m_st = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    int nst;
    bit ocp_seen;
    h_en  = {h_en[14:0], en};
    h_uv  = {h_uv[14:0], uvlo_ok};
    h_ot  = {h_ot[14:0], ot};
    h_ocp = {h_ocp[14:0], ocp};
    ocp_seen = h_ocp[2];
    nst = m_st;
    case (m_st)
      0: if (m_en_d) nst = 1;
      1: if (!m_en_d) nst = 0;
         else if (m_uv_d && !m_ot_d) begin nst = 2; m_cnt = 0; end
      2, 3: if (!m_en_d) nst = 0;
            else if (ocp_seen || m_ot_d) begin nst = 4; m_cnt = 0; m_fault = 1; end
            else if (!m_uv_d) nst = 1;
            else if (m_st == 2) begin
              if (m_cnt == SS - 1) nst = 3;
              else m_cnt++;
            end
      4: if (!m_en_d) nst = 0;
         else if (m_cnt == RETRY - 1) nst = 1;
         else m_cnt++;
      default: nst = 0;
    endcase
    if (nst == 0) m_fault = 0;
    m_st = nst;
    if (run_differs(h_en, m_en_d)) m_en_d = !m_en_d;
    if (run_differs(h_uv, m_uv_d)) m_uv_d = !m_uv_d;
    if (run_differs(h_ot, m_ot_d)) m_ot_d = !m_ot_d;
  endtask

  function automatic int m_code();
    if (m_st == 2)      return (m_cnt * 256) / SS;
    else if (m_st == 3) return 255;
    else                return 0;
  endfunction

  // per-cycle comparison against the model
  always @(posedge CELCLK) begin
    if (CELRST) model_reset();
    else        model_step();
    #1;
    if (chk_on && !CELRST) begin
      chk("state",     state,     m_st);
      chk("core_on",   core_on,   (m_st == 2 || m_st == 3) ? 1 : 0);
      chk("ss_active", ss_active, (m_st == 2) ? 1 : 0);
      chk("ss_code",   ss_code,   m_code());
      chk("fault",     fault,     m_fault);
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    step(3);
    chk("rst_state", state, 0);
    chk("rst_core_on", core_on, 0);
    chk("rst_ss_active", ss_active, 0);
    chk("rst_ss_code", ss_code, 0);
    chk("rst_fault", fault, 0);
    CELRST = 1'b0;
    chk_on = 1'b1;
    step(10);

    // glitch rejection
    en = 1'b1; step(3); en = 1'b0; step(12);
    chk("glitch3_state", state, 0);
    en = 1'b1; step(4); en = 1'b0; step(3);
    chk("glitch4_state", state, 1);
    step(30);

    // power-up
    en = 1'b1; step(6);
    chk("pu_edge6_state", state, 0);
    step(1);
    chk("pu_wait_state", state, 1);
    step(1);
    chk("pu_ss_state", state, 2);
    chk("pu_ss_core_on", core_on, 1);
    chk("pu_ss_active", ss_active, 1);
    chk("pu_ss_code0", ss_code, 0);
    step(64);
    chk("pu_ss_code40", ss_code, 8'h40);
    step(192);
    chk("pu_run_state", state, 3);
    chk("pu_run_code", ss_code, 8'hFF);
    chk("pu_run_ss_active", ss_active, 0);
    step(5);

    // overcurrent in RUN
    ocp = 1'b1; step(1); ocp = 1'b0; step(1);
    chk("ocp_edge2_state", state, 3);
    step(1);
    chk("ocp_hiccup_state", state, 4);
    chk("ocp_core_on", core_on, 0);
    chk("ocp_fault", fault, 1);
    step(1023);
    chk("hic_end_state", state, 4);
    step(1);
    chk("hic_retry_state", state, 1);
    chk("hic_retry_fault", fault, 1);
    step(1);
    chk("hic_ss_state", state, 2);
    step(256);
    chk("hic_run_state", state, 3);
    chk("hic_run_fault", fault, 1);
    step(3);

    // disable and overcurrent seen in the same cycle
    en = 1'b0; step(4);
    ocp = 1'b1; step(1); ocp = 1'b0; step(1);
    chk("prio_pre_state", state, 3);
    step(1);
    chk("prio_state", state, 0);
    chk("prio_fault", fault, 0);
    step(10);

    // UVLO drop during soft-start
    en = 1'b1; step(8);
    chk("uv_ss_state", state, 2);
    step(58);
    uvlo_ok = 1'b0; step(6);
    chk("uv_pre_code", ss_code, 8'h40);
    step(1);
    chk("uv_drop_state", state, 1);
    chk("uv_drop_code", ss_code, 0);
    chk("uv_drop_fault", fault, 0);
    uvlo_ok = 1'b1; step(7);
    chk("uv_restart_state", state, 2);
    chk("uv_restart_code", ss_code, 0);
    step(1);
    chk("uv_restart_code1", ss_code, 1);

    // asynchronous reset mid soft-start
    step(10);
    chk("pre_rst_core_on", core_on, 1);
    #1 CELRST = 1'b1;
    #1;
    chk("arst_core_on", core_on, 0);
    chk("arst_ss_active", ss_active, 0);
    chk("arst_ss_code", ss_code, 0);
    chk("arst_state", state, 0);
    step(2);
    CELRST = 1'b0;
    step(5);
    chk("post_rst_state", state, 0);
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
